// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling engine: mode encoding and the
// horizontal/vertical combine operator (max or add).
// No ports; pure package.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  // Container width for pool_combine; callers zero-extend operands into it
  // and truncate the result to the width they need.
  localparam int unsigned COMB_W = 32;

  // Max mode keeps the larger operand; avg mode accumulates so the final
  // stage can round-divide the four-pixel sum.
  function automatic logic [COMB_W-1:0] pool_combine(
    input pool_mode_t        m,
    input logic [COMB_W-1:0] a,
    input logic [COMB_W-1:0] b
  );
    if (m == POOL_AVG) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer of horizontal partial results, one entry per output column.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the owner gates wr_en with its own handshake.
// Ports: wr_en/wr_addr/wr_dat write port, rd_addr/rd_dat read port.
module pool_line_buf #(
  parameter int DEPTH = 4,
  parameter int DW    = 9,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  // Contents are don't-care after reset: every entry is written on an even
  // row before the odd row reads it.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 max / rounded-average pooling, raster-order input.
// Latency: pooled pixel registered 1 cycle after its odd-row odd-col input.
// Backpressure: in_ready = !out_valid || out_ready; a held output stalls all state.
// Ports: mode (sampled on first pixel of a frame), in_* / out_* valid-ready
// streams, out_last marks a frame's final output, busy spans a frame.
module pool2x2_stream #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  import pool_pkg::*;

  localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB_D = IMG_W / 2;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam int HW   = WIDTH + 1;  // horizontal partial (pair sum)
  localparam int SW   = WIDTH + 2;  // four-pixel sum

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $fatal(1, "pool2x2_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $fatal(1, "pool2x2_stream: IMG_H must be even and >= 2");
  end

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  pool_mode_t       mode_q, mode_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic             in_fire, out_fire;
  logic             frame_start, col_last, row_last;
  logic [HW-1:0]    hpart;
  logic [HW-1:0]    lb_rd;
  logic [AW-1:0]    lb_addr;
  logic             lb_we;
  logic [SW-1:0]    vsum;
  logic [SW-1:0]    avg_rnd;
  logic [WIDTH-1:0] result;

  assign in_ready = !out_valid_q || out_ready;

  // The latched mode is only consumed on odd columns, so it is always the
  // current frame's mode by the time any combine happens.
  always_comb begin
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid_q && out_ready;
    frame_start = (row_q == '0) && (col_q == '0);
    col_last    = (col_q == CW'(IMG_W - 1));
    row_last    = (row_q == RW'(IMG_H - 1));
    hpart       = HW'(pool_combine(mode_q, COMB_W'(hold_q), COMB_W'(in_data)));
    lb_addr     = AW'(col_q >> 1);
    lb_we       = in_fire && !row_q[0] && col_q[0];
    vsum        = SW'(pool_combine(mode_q, COMB_W'(hpart), COMB_W'(lb_rd)));
    avg_rnd     = (vsum + SW'(2)) >> 2;
    result      = (mode_q == POOL_AVG) ? avg_rnd[WIDTH-1:0] : vsum[WIDTH-1:0];
  end

  pool_line_buf #(
    .DEPTH (LB_D),
    .DW    (HW),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_addr),
    .wr_dat  (hpart),
    .rd_addr (lb_addr),
    .rd_dat  (lb_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;

    if (in_fire) begin
      if (frame_start) begin
        mode_d = pool_mode_t'(mode);
      end
      if (!col_q[0]) begin
        hold_d = in_data;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // A new result may load in the same cycle the previous one drains.
    if (in_fire && row_q[0] && col_q[0]) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_last_d  = row_last && col_last;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // Clear only when the last output leaves with no newer frame underway;
    // a first pixel accepted in the same cycle keeps busy high.
    if (out_fire && out_last_q && frame_start) begin
      busy_d = 1'b0;
    end
    if (in_fire && frame_start) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_MAX;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream on a 4x4 frame: a frame-array
// reference model predicts every pooled output, and literal tables pin it.
module tb_pool2x2_stream;

  localparam int WIDTH = 8;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int NPIX  = W * H;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs_q[$];
  int   frame_px[H][W];
  int   pix_src[NPIX];
  int   m_idx;
  bit   m_mode;
  int   rdy_mode;

  pool2x2_stream #(
    .WIDTH (WIDTH),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model and compare process. At each negedge the DUT shows the
  // state after the previous posedge; the model then absorbs the transfers
  // that the coming posedge will perform.
  initial begin : p_compare
    exp_t ent;
    int   r, c, a, b, d, e, v;
    bit   prev_stall;
    int   prev_data;
    m_idx      = 0;
    m_mode     = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_idx      = 0;
        prev_stall = 1'b0;
        continue;
      end
      check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("busy", int'(busy), int'(m_idx != 0 || exp_q.size() != 0));
      if (prev_stall) begin
        check("stall_hold", int'({out_valid, out_data}), (1 << WIDTH) | prev_data);
      end
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", int'(out_data), exp_q[0].data);
        check("out_last", int'(out_last), int'(exp_q[0].last));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        ent.data = int'(out_data);
        ent.last = out_last;
        obs_q.push_back(ent);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        r = m_idx / W;
        c = m_idx % W;
        if (m_idx == 0) m_mode = mode;
        frame_px[r][c] = int'(in_data);
        if ((r % 2) == 1 && (c % 2) == 1) begin
          a = frame_px[r-1][c-1];
          b = frame_px[r-1][c];
          d = frame_px[r][c-1];
          e = frame_px[r][c];
          if (m_mode) begin
            v = (a + b + d + e + 2) / 4;
          end else begin
            v = a;
            if (b > v) v = b;
            if (d > v) v = d;
            if (e > v) v = e;
          end
          ent.data = v;
          ent.last = (m_idx == NPIX - 1);
          exp_q.push_back(ent);
        end
        m_idx = (m_idx + 1) % NPIX;
      end
    end
  end

  // Downstream: 0 = always ready, 1 = hold each output 5 cycles, 2 = random.
  initial begin : p_ready
    int stall_cnt;
    bit prev_ov;
    stall_cnt = 0;
    prev_ov   = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev_ov && out_ready) stall_cnt = 0;
      case (rdy_mode)
        1: begin
          if (out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      prev_ov = out_valid;
    end
  end

  // Sends n pixels from pix_src starting at a frame boundary. Frame-start
  // pixels carry m0 / m1 alternately; all other pixels carry a random mode.
  task automatic send_pixels(input int n, input bit m0, input bit m1, input bit gaps);
    int g;
    int budget;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(pix_src[k % NPIX]);
      if ((k % NPIX) == 0) mode = (((k / NPIX) % 2) == 0) ? m0 : m1;
      else                 mode = 1'($urandom_range(0, 1));
      budget = 0;
      forever begin
        @(negedge clk);
        if (in_ready) begin
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
        #1;
        budget++;
        if (budget > 100) begin
          check("in_accept_timeout", int'(in_ready), 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 300) check("drain_timeout", exp_q.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_obs(input string name, input int n, input int vals[8]);
    check({name, "_count"}, obs_q.size(), n);
    for (int i = 0; i < obs_q.size() && i < n; i++) begin
      check({name, "_data"}, obs_q[i].data, vals[i]);
      check({name, "_last"}, int'(obs_q[i].last), int'((i % 4) == 3));
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) pix_src[i] = i;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NPIX; i++) pix_src[i] = v;
  endtask

  initial begin : p_main
    rdy_mode = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    mode     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, max then average.
    fill_ramp();
    obs_q.delete();
    send_pixels(NPIX, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check_obs("max_ramp", 4, '{5, 7, 13, 15, 0, 0, 0, 0});

    obs_q.delete();
    send_pixels(NPIX, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check_obs("avg_ramp", 4, '{3, 5, 11, 13, 0, 0, 0, 0});

    // Saturated and zero frames.
    fill_const(255);
    obs_q.delete();
    send_pixels(NPIX, 1'b1, 1'b1, 1'b0);
    wait_idle();
    check_obs("avg_255", 4, '{255, 255, 255, 255, 0, 0, 0, 0});

    fill_const(0);
    obs_q.delete();
    send_pixels(NPIX, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check_obs("max_zero", 4, '{0, 0, 0, 0, 0, 0, 0, 0});

    // Input gaps with each output stalled 5 cycles.
    fill_ramp();
    rdy_mode = 1;
    obs_q.delete();
    send_pixels(NPIX, 1'b0, 1'b0, 1'b1);
    wait_idle();
    check_obs("stall_ramp", 4, '{5, 7, 13, 15, 0, 0, 0, 0});
    rdy_mode = 0;

    // Two back-to-back frames, avg then max, mode wiggling mid-frame.
    obs_q.delete();
    send_pixels(2 * NPIX, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check_obs("b2b", 8, '{3, 5, 11, 13, 5, 7, 13, 15});

    // Abort a frame after 6 pixels, then run a clean frame.
    obs_q.delete();
    send_pixels(6, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_no_output", obs_q.size(), 0);
    obs_q.delete();
    send_pixels(NPIX, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check_obs("post_abort", 4, '{5, 7, 13, 15, 0, 0, 0, 0});

    // Random frames, stalled and random downstream, some back-to-back.
    for (int f = 0; f < 8; f++) begin
      rdy_mode = (f < 4) ? 1 : 2;
      for (int i = 0; i < NPIX; i++) pix_src[i] = $urandom_range(0, 255);
      send_pixels(((f % 2) == 0) ? NPIX : 2 * NPIX,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
    end
    rdy_mode = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
